// File: rtl/ahb_tgen_master.sv
// ahb_tgen_master: AHB write-fill / read-check traffic generator.
// Define AHB_TGEN_FIRST_ERR_EN to capture the first mismatch address.
module ahb_tgen_master #(
    parameter int BURST_LEN = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 HRESETn,
    input  logic                 HCLK,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [31:0]          HWDATA,
    input  logic [31:0]          HRDATA,
    input  logic [1:0]           HRESP,
    input  logic                 HREADY,
    input  logic                 start,
    input  logic                 op,
    input  logic [31:0]          addr,
    input  logic [CNT_WIDTH-1:0] num,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic                 resp_err,
    output logic [31:0]          first_err_addr
);

    localparam int BL = (BURST_LEN == 4 || BURST_LEN == 8 ||
                         BURST_LEN == 16) ? BURST_LEN : 0;

    localparam logic [2:0] BURST_CODE =
        (BL == 4)  ? 3'b011 :
        (BL == 8)  ? 3'b101 :
        (BL == 16) ? 3'b111 : 3'b001;

    localparam logic [CNT_WIDTH-1:0] CHUNK_MASK =
        (BL == 0) ? '0 : CNT_WIDTH'(BL - 1);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [1:0] R_ERROR  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_DONE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] left;
    logic [CNT_WIDTH-1:0] beat;
    logic [31:0]          pat;
    logic                 dphase;
    logic                 dread;

    logic [31:0]          addr_nxt;
    logic [CNT_WIDTH-1:0] beat_nxt;
    logic                 nseq_nxt;
    logic                 data_ok;
    logic                 mismatch;
    logic                 bus_err;

    assign HSIZE  = 3'b010;
    assign HBURST = BURST_CODE;

    assign addr_nxt = HADDR + 32'd4;
    assign beat_nxt = beat + 1'b1;

    // New NONSEQ at every fixed-burst chunk start and at each 1KB boundary
    assign nseq_nxt = ((BL != 0) && ((beat_nxt & CHUNK_MASK) == '0)) ||
                      (addr_nxt[9:0] == 10'd0);

    assign data_ok  = dphase && HREADY;
    assign mismatch = data_ok && dread && (HRDATA != HWDATA);
    assign bus_err  = dphase && !HREADY && (HRESP == R_ERROR);

`ifdef AHB_TGEN_FIRST_ERR_EN
    logic [31:0] daddr;
    logic        ferr_seen;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            daddr          <= '0;
            ferr_seen      <= 1'b0;
            first_err_addr <= '0;
        end else begin
            if (state == S_ADDR && HREADY && !bus_err)
                daddr <= HADDR;
            if (state == S_IDLE && start) begin
                ferr_seen      <= 1'b0;
                first_err_addr <= '0;
            end else if (mismatch && !ferr_seen) begin
                ferr_seen      <= 1'b1;
                first_err_addr <= daddr;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge HCLK) begin
        if (HRESETn && mismatch)
            $display("%0t ahb_tgen mismatch addr=%h exp=%h act=%h",
                     $time, daddr, HWDATA, HRDATA);
    end
`endif
`else
    assign first_err_addr = '0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            HADDR    <= '0;
            HTRANS   <= T_IDLE;
            HWRITE   <= 1'b0;
            HWDATA   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_cnt  <= '0;
            resp_err <= 1'b0;
            left     <= '0;
            beat     <= '0;
            pat      <= '0;
            dphase   <= 1'b0;
            dread    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (mismatch && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
            if (data_ok)
                dphase <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err_cnt  <= '0;
                        resp_err <= 1'b0;
                        if (num == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= S_ADDR;
                            busy   <= 1'b1;
                            HADDR  <= addr & ~32'h3;
                            HTRANS <= T_NONSEQ;
                            HWRITE <= ~op;
                            left   <= num;
                            beat   <= '0;
                            pat    <= seed;
                        end
                    end
                end

                S_ADDR: begin
                    if (bus_err) begin
                        state    <= S_DONE;
                        HTRANS   <= T_IDLE;
                        resp_err <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        dphase   <= 1'b0;
                    end else if (HREADY) begin
                        HWDATA <= pat;
                        pat    <= pat + 32'd1;
                        dphase <= 1'b1;
                        dread  <= ~HWRITE;
                        if (left == CNT_WIDTH'(1)) begin
                            state  <= S_LAST;
                            HTRANS <= T_IDLE;
                        end else begin
                            HADDR  <= addr_nxt;
                            HTRANS <= nseq_nxt ? T_NONSEQ : T_SEQ;
                            beat   <= beat_nxt;
                            left   <= left - 1'b1;
                        end
                    end
                end

                S_LAST: begin
                    if (bus_err) begin
                        state    <= S_DONE;
                        resp_err <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        dphase   <= 1'b0;
                    end else if (HREADY) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_tgen_master.sv
// tb_ahb_tgen_master: directed checks of ahb_tgen_master against a
// word-addressed AHB memory slave with wait-state and ERROR injection.
module tb_ahb_tgen_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata = '0;
    logic [1:0]  hresp = 2'b00;
    logic        hready = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] num = '0;
    logic [31:0] seed = '0;
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;
    logic        resp_err;
    logic [31:0] ferr;

    logic [31:0] haddr4;
    logic [1:0]  htrans4;
    logic        hwrite4;
    logic [2:0]  hsize4;
    logic [2:0]  hburst4;
    logic [31:0] hwdata4;
    logic        start4 = 1'b0;
    logic        op4 = 1'b0;
    logic [31:0] addr4 = '0;
    logic [15:0] num4 = '0;
    logic [31:0] seed4 = '0;
    logic        busy4;
    logic        done4;
    logic [15:0] err_cnt4;
    logic        resp_err4;
    logic [31:0] ferr4;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ahb_tgen_master dut (
        .HRESETn(rst_n), .HCLK(clk),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HRDATA(hrdata), .HRESP(hresp), .HREADY(hready),
        .start(start), .op(op), .addr(addr), .num(num), .seed(seed),
        .busy(busy), .done(done), .err_cnt(err_cnt),
        .resp_err(resp_err), .first_err_addr(ferr)
    );

    ahb_tgen_master #(.BURST_LEN(4)) dut4 (
        .HRESETn(rst_n), .HCLK(clk),
        .HADDR(haddr4), .HTRANS(htrans4), .HWRITE(hwrite4),
        .HSIZE(hsize4), .HBURST(hburst4), .HWDATA(hwdata4),
        .HRDATA(32'h0), .HRESP(2'b00), .HREADY(1'b1),
        .start(start4), .op(op4), .addr(addr4), .num(num4), .seed(seed4),
        .busy(busy4), .done(done4), .err_cnt(err_cnt4),
        .resp_err(resp_err4), .first_err_addr(ferr4)
    );

    // memory slave model
    logic [31:0] mem [0:1023];
    int          delay = 0;
    int          err_beat = -1;
    int          beat_no = 0;
    int          wcnt = 0;
    logic        err2 = 1'b0;
    logic        dp_v = 1'b0;
    logic        dp_w = 1'b0;
    logic [9:0]  dp_a = '0;

    always @(posedge clk) begin
        if (start)
            beat_no <= 0;
        else if (hready && htrans[1])
            beat_no <= beat_no + 1;
        if (hready) begin
            if (dp_v && dp_w && hresp == 2'b00)
                mem[dp_a] <= hwdata;
            dp_v   <= htrans[1];
            dp_a   <= haddr[11:2];
            dp_w   <= hwrite;
            hresp  <= 2'b00;
            hready <= 1'b1;
            if (htrans[1]) begin
                hrdata <= mem[haddr[11:2]];
                if (beat_no == err_beat) begin
                    hready <= 1'b0;
                    hresp  <= 2'b01;
                    err2   <= 1'b1;
                end else if (delay > 0) begin
                    hready <= 1'b0;
                    wcnt   <= delay - 1;
                end
            end
        end else if (err2) begin
            hready <= 1'b1;
            err2   <= 1'b0;
        end else if (wcnt > 0) begin
            wcnt <= wcnt - 1;
        end else begin
            hready <= 1'b1;
        end
    end

    // bus monitor, sampled on the falling edge
    logic [31:0] acc_addr [$];
    logic [1:0]  acc_trans [$];
    logic        acc_wr [$];
    logic [31:0] ns4_addr [$];
    int          n4_acc = 0;
    int          stab_bad = 0;
    int          err_seen = 0;
    int          err_idle_bad = 0;
    logic        chk_stab = 1'b0;
    logic        p_hready = 1'b1;
    logic        p_err = 1'b0;
    logic [31:0] p_haddr = '0;
    logic [31:0] p_hwdata = '0;

    always @(negedge clk) begin
        if (htrans[1] && hready) begin
            acc_addr.push_back(haddr);
            acc_trans.push_back(htrans);
            acc_wr.push_back(hwrite);
        end
        if (chk_stab && !p_hready &&
            (haddr != p_haddr || hwdata != p_hwdata))
            stab_bad++;
        if (p_err && htrans != 2'b00)
            err_idle_bad++;
        p_err = (hresp == 2'b01) && !hready;
        if (p_err)
            err_seen++;
        p_hready = hready;
        p_haddr  = haddr;
        p_hwdata = hwdata;
        if (htrans4 == 2'b10)
            ns4_addr.push_back(haddr4);
        if (htrans4[1])
            n4_acc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // called at a falling edge; returns cycles from start to done
    task automatic run(input logic o, input logic [31:0] a,
                       input logic [15:0] n, input logic [31:0] s,
                       output int cyc, output logic busy1);
        op = o; addr = a; num = n; seed = s; start = 1'b1;
        cyc = 0;
        busy1 = 1'b0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) busy1 = busy;
        end while (!done && cyc < 500);
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd0);
    endtask

    task automatic run4(input logic o, input logic [31:0] a,
                        input logic [15:0] n, input logic [31:0] s,
                        output int cyc);
        op4 = o; addr4 = a; num4 = n; seed4 = s; start4 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            cyc++;
        end while (!done4 && cyc < 500);
        chk("done4_seen", {63'd0, done4}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int   cyc;
        logic b1;
        int   base;
        logic [31:0] exp_ferr;

        repeat (2) @(negedge clk);
        chk("rst_htrans", {62'd0, htrans}, 64'd0);
        chk("rst_haddr", {32'd0, haddr}, 64'd0);
        chk("rst_hwrite", {63'd0, hwrite}, 64'd0);
        chk("rst_hsize", {61'd0, hsize}, 64'd2);
        chk("rst_hburst", {61'd0, hburst}, 64'd1);
        chk("rst_hburst4", {61'd0, hburst4}, 64'd3);
        chk("rst_hwdata", {32'd0, hwdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("rst_ferr", {32'd0, ferr}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // zero-wait write-fill
        base = acc_addr.size();
        run(1'b0, 32'h100, 16'd8, 32'hA000_0000, cyc, b1);
        chk("wf_cycles", 64'(cyc), 64'd10);
        chk("wf_busy", {63'd0, b1}, 64'd1);
        chk("wf_beats", 64'(acc_addr.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wf_trans%0d", i), {62'd0, acc_trans[base + i]},
                (i == 0) ? 64'd2 : 64'd3);
            chk($sformatf("wf_addr%0d", i), {32'd0, acc_addr[base + i]},
                64'h100 + 64'(4 * i));
            chk($sformatf("wf_wr%0d", i), {63'd0, acc_wr[base + i]}, 64'd1);
            chk($sformatf("wf_mem%0d", i), {32'd0, mem[64 + i]},
                64'hA000_0000 + 64'(i));
        end

        // read-check with three wait states per beat
        delay = 3;
        chk_stab = 1'b1;
        run(1'b1, 32'h100, 16'd8, 32'hA000_0000, cyc, b1);
        chk_stab = 1'b0;
        delay = 0;
        chk("rc_cycles", 64'(cyc), 64'd34);
        chk("rc_err_cnt", {48'd0, err_cnt}, 64'd0);
        chk("rc_stable", 64'(stab_bad), 64'd0);
        chk("rc_resp_err", {63'd0, resp_err}, 64'd0);

        // every beat mismatches
        run(1'b1, 32'h100, 16'd8, 32'hA000_0001, cyc, b1);
        chk("mm_err_cnt", {48'd0, err_cnt}, 64'd8);
`ifdef AHB_TGEN_FIRST_ERR_EN
        exp_ferr = 32'h100;
`else
        exp_ferr = 32'h0;
`endif
        chk("mm_ferr", {32'd0, ferr}, {32'd0, exp_ferr});

        // num=0: no bus traffic, done the next cycle
        base = acc_addr.size();
        run(1'b0, 32'h180, 16'd0, 32'h1, cyc, b1);
        chk("z_cycles", 64'(cyc), 64'd1);
        chk("z_busy", {63'd0, b1}, 64'd0);
        chk("z_beats", 64'(acc_addr.size() - base), 64'd0);
        chk("z_err_cnt", {48'd0, err_cnt}, 64'd0);

        // INCR4 chunks across a 1KB boundary
        base = ns4_addr.size();
        n4_acc = 0;
        run4(1'b0, 32'h3F8, 16'd8, 32'h0, cyc);
        chk("b4_cycles", 64'(cyc), 64'd10);
        chk("b4_beats", 64'(n4_acc), 64'd8);
        chk("b4_nseq_n", 64'(ns4_addr.size() - base), 64'd3);
        chk("b4_nseq0", {32'd0, ns4_addr[base]}, 64'h3F8);
        chk("b4_nseq1", {32'd0, ns4_addr[base + 1]}, 64'h400);
        chk("b4_nseq2", {32'd0, ns4_addr[base + 2]}, 64'h408);
        run4(1'b1, 32'h0, 16'd3, 32'h0, cyc);
        chk("b4_rd_err_cnt", {48'd0, err_cnt4}, 64'd2);

        // ERROR response on beat 2 of 8
        err_beat = 2;
        base = acc_addr.size();
        run(1'b0, 32'h200, 16'd8, 32'h0, cyc, b1);
        err_beat = -1;
        chk("er_cycles", 64'(cyc), 64'd5);
        chk("er_beats", 64'(acc_addr.size() - base), 64'd3);
        chk("er_seen", 64'(err_seen), 64'd1);
        chk("er_idle", 64'(err_idle_bad), 64'd0);
        chk("er_resp_err", {63'd0, resp_err}, 64'd1);
        chk("er_mem0", {32'd0, mem[128]}, 64'd0);
        chk("er_mem1", {32'd0, mem[129]}, 64'd1);
        run(1'b1, 32'h100, 16'd8, 32'hA000_0000, cyc, b1);
        chk("er_clr_resp", {63'd0, resp_err}, 64'd0);
        chk("er_clr_cnt", {48'd0, err_cnt}, 64'd0);

        // reset asserted mid-burst
        delay = 1;
        op = 1'b0; addr = 32'h300; num = 16'd16; seed = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("ra_busy_pre", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_htrans", {62'd0, htrans}, 64'd0);
        chk("ra_busy", {63'd0, busy}, 64'd0);
        chk("ra_haddr", {32'd0, haddr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        delay = 0;
        repeat (4) @(negedge clk);
        chk("ra_idle_after", {62'd0, htrans}, 64'd0);
        run(1'b0, 32'h300, 16'd4, 32'h55, cyc, b1);
        chk("ra_cycles", 64'(cyc), 64'd6);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ra_mem%0d", i), {32'd0, mem[192 + i]},
                64'h55 + 64'(i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
